// File: rtl/bias_act_output_stage.sv
// Bias-add + activation output stage with a 2-entry result FIFO, sticky flags and a txn counter.
// Define ACT_RELU_EN to apply ReLU (NaN preserved); otherwise activation is identity.

module add_sub #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic [exp_width+mant_width-1:0] a,
  input  logic [exp_width+mant_width-1:0] b,
  input  logic                            operation,
  input  logic [2:0]                      round_mode,
  output logic [exp_width+mant_width-1:0] result,
  output logic [4:0]                      exceptions
);
  localparam int W  = exp_width + mant_width;
  localparam int FW = mant_width - 1;
  localparam int XW = mant_width + 3;
  typedef logic [exp_width+1:0] ext_t;
  localparam ext_t ONE_E = ext_t'(1);
  localparam ext_t EMAX_X = ext_t'((1 << exp_width) - 1);
  localparam logic [exp_width-1:0] EMAX = '1;

  logic                  sa, sb, sr, swap, s_big, s_small, nan_a, nan_b, inf_a, inf_b, snan;
  logic                  eff_sub, sticky, found, tiny, lsb, grd, rs, inc, to_inf;
  logic                  invalid, overflow, underflow, inexact;
  logic [exp_width-1:0]  ea, eb;
  logic [FW-1:0]         fa, fb;
  logic [mant_width-1:0] m_big, m_small;
  logic [mant_width:0]   rnd;
  logic [XW-1:0]         mx, my, shifted;
  logic [XW:0]           sum;
  ext_t                  e_big, e_small, diff, ex, lz, sh;

  always_comb begin
    sa    = a[W-1];
    sb    = b[W-1] ^ operation;
    ea    = a[W-2 -: exp_width];
    eb    = b[W-2 -: exp_width];
    fa    = a[FW-1:0];
    fb    = b[FW-1:0];
    nan_a = (ea == EMAX) && (fa != '0);
    nan_b = (eb == EMAX) && (fb != '0);
    inf_a = (ea == EMAX) && (fa == '0);
    inf_b = (eb == EMAX) && (fb == '0);
    snan  = (nan_a && !fa[FW-1]) || (nan_b && !fb[FW-1]);

    // Order operands by magnitude so the subtraction never goes negative.
    swap    = {eb, fb} > {ea, fa};
    s_big   = swap ? sb : sa;
    s_small = swap ? sa : sb;
    e_big   = ext_t'(swap ? eb : ea);
    e_small = ext_t'(swap ? ea : eb);
    m_big   = swap ? {eb != '0, fb} : {ea != '0, fa};
    m_small = swap ? {ea != '0, fa} : {eb != '0, fb};
    if (e_big == '0) e_big = ONE_E;
    if (e_small == '0) e_small = ONE_E;
    diff = e_big - e_small;

    mx     = {m_big, 3'b000};
    my     = {m_small, 3'b000};
    sticky = 1'b0;
    for (int i = 0; i < XW; i++)
      if ((ext_t'(i) < diff) && my[i]) sticky = 1'b1;
    shifted    = (diff >= ext_t'(XW)) ? '0 : (my >> diff);
    shifted[0] = shifted[0] | sticky;

    eff_sub = s_big ^ s_small;
    sum     = eff_sub ? ({1'b0, mx} - {1'b0, shifted}) : ({1'b0, mx} + {1'b0, shifted});
    ex      = e_big;
    if (sum[XW]) begin
      sum = {1'b0, sum[XW:2], sum[1] | sum[0]};
      ex  = ex + ONE_E;
    end

    lz    = '0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found && !sum[i]) lz = lz + ONE_E;
      else found = 1'b1;
    end
    // Left-normalise, but stop at the minimum exponent so subnormals stay subnormal.
    sh  = (lz < ex - ONE_E) ? lz : ex - ONE_E;
    sum = sum << sh;
    ex  = ex - sh;

    tiny = !sum[XW-1];
    lsb  = sum[3];
    grd  = sum[2];
    rs   = sum[1] | sum[0];
    sr   = s_big;
    if (sum == '0) sr = eff_sub ? (round_mode == 3'd2) : s_big;

    case (round_mode)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sr && (grd || rs);
      3'd3:    inc = !sr && (grd || rs);
      3'd4:    inc = grd;
      default: inc = grd && (rs || lsb);
    endcase
    rnd = {1'b0, sum[XW-1:3]} + {{mant_width{1'b0}}, inc};
    if (rnd[mant_width]) begin
      rnd = rnd >> 1;
      ex  = ex + ONE_E;
    end

    inexact   = grd | rs;
    overflow  = ex >= EMAX_X;
    underflow = tiny && inexact;
    invalid   = 1'b0;
    to_inf    = (round_mode == 3'd0) || (round_mode == 3'd4) ||
                (round_mode == 3'd3 && !sr) || (round_mode == 3'd2 && sr);
    if (overflow) begin
      inexact = 1'b1;
      result  = to_inf ? {sr, EMAX, {FW{1'b0}}}
                       : {sr, {(exp_width-1){1'b1}}, 1'b0, {FW{1'b1}}};
    end else begin
      result = {sr, (rnd[mant_width-1] ? ex[exp_width-1:0] : {exp_width{1'b0}}), rnd[FW-1:0]};
    end

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      result  = {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};
      invalid = snan || (inf_a && inf_b && (sa != sb));
      {overflow, underflow, inexact} = 3'b000;
    end else if (inf_a || inf_b) begin
      result = {inf_a ? sa : sb, EMAX, {FW{1'b0}}};
      {overflow, underflow, inexact} = 3'b000;
    end
    exceptions = {invalid, 1'b0, overflow, underflow, inexact};
  end
endmodule

module bias_act_output_stage #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] c1,
  input  logic [exp_width+mant_width-1:0] c2,
  input  logic [4:0]                      in_exceptions,
  input  logic [exp_width+mant_width-1:0] bias1,
  input  logic [exp_width+mant_width-1:0] bias2,
  input  logic [2:0]                      round_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] y1,
  output logic [exp_width+mant_width-1:0] y2,
  output logic [4:0]                      out_exceptions,
  output logic [4:0]                      exc_sticky,
  input  logic                            clr_sticky,
  output logic [CNT_WIDTH-1:0]            txn_count
);
  localparam int W = exp_width + mant_width;

  logic [W-1:0] s1, s2, act1, act2, head_y1, head_y2;
  logic [4:0]   addexc1, addexc2, entry_flags, head_fl;
  logic         accept, pop, wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [1:0]   count_reg, count_next;
  logic [W-1:0] mem_y1_reg [2];
  logic [W-1:0] mem_y2_reg [2];
  logic [4:0]   mem_fl_reg [2];

  add_sub #(.exp_width(exp_width), .mant_width(mant_width)) u_add1 (
    .a(c1), .b(bias1), .operation(1'b0), .round_mode(round_mode), .result(s1), .exceptions(addexc1)
  );
  add_sub #(.exp_width(exp_width), .mant_width(mant_width)) u_add2 (
    .a(c2), .b(bias2), .operation(1'b0), .round_mode(round_mode), .result(s2), .exceptions(addexc2)
  );

  function automatic logic [W-1:0] activate(input logic [W-1:0] s);
`ifdef ACT_RELU_EN
    if (s[W-1] && !((s[W-2 -: exp_width] == '1) && (s[mant_width-2:0] != '0))) return '0;
`endif
    return s;
  endfunction

  assign act1        = activate(s1);
  assign act2        = activate(s2);
  assign entry_flags = in_exceptions | addexc1 | addexc2;
  assign in_ready    = !count_reg[1];
  assign out_valid   = (count_reg != 2'd0);
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  // The output registers track the head the FIFO will present after this edge,
  // so they hold their last value once the FIFO drains.
  always_comb begin
    rd_ptr_next = rd_ptr_reg ^ pop;
    count_next  = count_reg + {1'b0, accept} - {1'b0, pop};
    if (accept && (wr_ptr_reg == rd_ptr_next)) begin
      head_y1 = act1;
      head_y2 = act2;
      head_fl = entry_flags;
    end else begin
      head_y1 = mem_y1_reg[rd_ptr_next];
      head_y2 = mem_y2_reg[rd_ptr_next];
      head_fl = mem_fl_reg[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_y1_reg[i] <= '0;
        mem_y2_reg[i] <= '0;
        mem_fl_reg[i] <= '0;
      end
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      count_reg      <= 2'd0;
      y1             <= '0;
      y2             <= '0;
      out_exceptions <= '0;
      exc_sticky     <= '0;
      txn_count      <= '0;
    end else begin
      if (accept) begin
        mem_y1_reg[wr_ptr_reg] <= act1;
        mem_y2_reg[wr_ptr_reg] <= act2;
        mem_fl_reg[wr_ptr_reg] <= entry_flags;
        wr_ptr_reg             <= !wr_ptr_reg;
        txn_count              <= txn_count + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != 2'd0) begin
        y1             <= head_y1;
        y2             <= head_y2;
        out_exceptions <= head_fl;
      end
      exc_sticky <= (clr_sticky ? 5'd0 : exc_sticky) | (accept ? entry_flags : 5'd0);
    end
  end
endmodule

// File: tb/tb_bias_act_output_stage.sv
// Directed scoreboard bench for bias_act_output_stage; expectations follow ACT_RELU_EN when defined.
module tb_bias_act_output_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [31:0] c1, c2, bias1, bias2, y1, y2;
  logic [4:0]  in_exceptions, out_exceptions, exc_sticky;
  logic [2:0]  round_mode;
  logic [15:0] txn_count;

  typedef struct packed {
    logic [31:0] y1;
    logic [31:0] y2;
    logic [4:0]  fl;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] cur_y1, cur_y2;
  logic [4:0]  cur_fl, exp_sticky;
  logic [15:0] exp_txn;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] tab_c [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] tab_s [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  bias_act_output_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c1(c1), .c2(c2), .in_exceptions(in_exceptions), .bias1(bias1), .bias2(bias2),
    .round_mode(round_mode), .out_valid(out_valid), .out_ready(out_ready),
    .y1(y1), .y2(y2), .out_exceptions(out_exceptions), .exc_sticky(exc_sticky),
    .clr_sticky(clr_sticky), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] act(input logic [31:0] s);
`ifdef ACT_RELU_EN
    if (s[31] && !((s[30:23] == 8'hFF) && (s[22:0] != 23'd0))) return 32'h0;
`endif
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] a1, input logic [31:0] b1v, input logic [31:0] a2,
                      input logic [31:0] b2v, input logic [4:0] exc, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [4:0] addfl);
    in_valid      = 1'b1;
    c1            = a1;
    bias1         = b1v;
    c2            = a2;
    bias2         = b2v;
    in_exceptions = exc;
    cur_y1        = act(s1);
    cur_y2        = act(s2);
    cur_fl        = exc | addfl;
  endtask

  // One clock: scoreboard pop/compare and push at the negedge, return just after the posedge.
  task automatic cycle();
    logic acc;
    @(negedge clk);
    if (out_valid && out_ready) begin
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_pop: observed out_valid=1 expected empty scoreboard to keep out_valid=0");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("pop_y1", {32'd0, y1}, {32'd0, e.y1});
        check("pop_y2", {32'd0, y2}, {32'd0, e.y2});
        check("pop_flags", {59'd0, out_exceptions}, {59'd0, e.fl});
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      sb_q.push_back('{cur_y1, cur_y2, cur_fl});
      exp_txn = exp_txn + 16'd1;
    end
    exp_sticky = (clr_sticky ? 5'd0 : exp_sticky) | (acc ? cur_fl : 5'd0);
    $display("[TB] t=%0t in_valid=%0b in_ready=%0b out_valid=%0b out_ready=%0b y1=%h y2=%h exc=%b",
             $time, in_valid, in_ready, out_valid, out_ready, y1, y2, out_exceptions);
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_txn"}, {48'd0, txn_count}, {48'd0, exp_txn});
    check({tag, "_sticky"}, {59'd0, exc_sticky}, {59'd0, exp_sticky});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    c1 = '0; c2 = '0; bias1 = '0; bias2 = '0; in_exceptions = '0; round_mode = 3'd0;
    cur_y1 = '0; cur_y2 = '0; cur_fl = '0; exp_sticky = '0; exp_txn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y1", {32'd0, y1}, 64'd0);
    check("rst_y2", {32'd0, y2}, 64'd0);
    check("rst_flags", {59'd0, out_exceptions}, 64'd0);
    check_status("rst");

    // 2.0+1.0 and -3.0+1.0
    out_ready = 1'b1;
    send(32'h40000000, 32'h3F800000, 32'hC0400000, 32'h3F800000, 5'd0, 32'h40400000, 32'hC0000000, 5'd0);
    cycle();
    in_valid = 1'b0;
    check("basic_valid", {63'd0, out_valid}, 64'd1);
    check("basic_y1", {32'd0, y1}, 64'h40400000);
`ifdef ACT_RELU_EN
    check("basic_y2", {32'd0, y2}, 64'h00000000);
`else
    check("basic_y2", {32'd0, y2}, 64'hC0000000);
`endif
    check_status("basic");
    cycle();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("hold_y1", {32'd0, y1}, 64'h40400000);

    // Backpressure: three offers, two accepted
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F000000, 5'd0, 32'h40000000, 32'hBF000000, 5'd0);
    cycle();
    send(32'h40A00000, 32'hBF800000, 32'h80000000, 32'h80000000, 5'd0, 32'h40800000, 32'h80000000, 5'd0);
    cycle();
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    send(32'h3FC00000, 32'h3F000000, 32'h00000000, 32'h00000000, 5'd0, 32'h40000000, 32'h0, 5'd0);
    cycle();
    check("full_in_ready2", {63'd0, in_ready}, 64'd0);
    check_status("full");
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("after_pop_in_ready", {63'd0, in_ready}, 64'd1);
    cycle();
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    check_status("bp");

    // Simultaneous push and pop with one entry held
    out_ready = 1'b0;
    send(32'hC0000000, 32'h00000000, 32'h3F800000, 32'hBF800000, 5'd0, 32'hC0000000, 32'h00000000, 5'd0);
    cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(tab_c[k], 32'h3F800000, tab_c[k], 32'h00000000, 5'd0, tab_s[k], tab_c[k], 5'd0);
      cycle();
      check("pp_valid", {63'd0, out_valid}, 64'd1);
      check("pp_in_ready", {63'd0, in_ready}, 64'd1);
      check("pp_head_y1", {32'd0, y1}, {32'd0, tab_s[k]});
    end
    in_valid = 1'b0;
    cycle();
    check("pp_drained", {63'd0, out_valid}, 64'd0);

    // Rounding boundary: 1.0 + 2^-30 is inexact; RUP bumps the LSB
    send(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h00000000, 5'd0, 32'h3F800000, 32'h3F800000, 5'b00001);
    cycle();
    round_mode = 3'd3;
    send(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h00000000, 5'd0, 32'h3F800001, 32'h3F800000, 5'b00001);
    cycle();
    round_mode = 3'd0;
    in_valid = 1'b0;
    cycle();
    cycle();
    check_status("round");

    // Sticky flags: clear coincident with new flags keeps the new ones
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 5'b00100, 32'h40000000, 32'h00000000, 5'd0);
    cycle();
    check("sticky_first", {59'd0, exc_sticky}, 64'h4);
    clr_sticky = 1'b1;
    send(32'h7FC00000, 32'h00000000, 32'h00000000, 32'h00000000, 5'b00001, 32'h7FC00000, 32'h00000000, 5'd0);
    cycle();
    clr_sticky = 1'b0;
    in_valid = 1'b0;
    check("sticky_second", {59'd0, exc_sticky}, 64'h1);
    check("nan_y1", {32'd0, y1}, 64'h7FC00000);
    check_status("sticky");
    cycle();

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    send(32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 5'b10000, 32'h40400000, 32'h40400000, 5'd0);
    cycle();
    cycle();
    in_valid = 1'b0;
    check("pre_rst_full", {63'd0, in_ready}, 64'd0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_y1", {32'd0, y1}, 64'd0);
    check("arst_y2", {32'd0, y2}, 64'd0);
    check("arst_flags", {59'd0, out_exceptions}, 64'd0);
    sb_q.delete();
    exp_txn = '0;
    exp_sticky = '0;
    check_status("arst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycle();
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
